// File: rtl/lab1_pkg.sv
// ---------------------------------------------------------------------------
// lab1_pkg
// Shared constants and types for the lab1 switch/LED slice.
//   CLK_HZ                  - system clock frequency (HSOSC, 48 MHz)
//   DEBOUNCE_MS             - switch settling window in milliseconds
//   DEBOUNCE_CYCLES_DEFAULT - settling window expressed in clk cycles
//   sw_t                    - raw/debounced 4-bit DIP-switch vector
// ---------------------------------------------------------------------------
package lab1_pkg;

    localparam int CLK_HZ                  = 48_000_000;
    localparam int DEBOUNCE_MS             = 10;
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

    typedef logic [3:0] sw_t;

endpackage

// File: rtl/switch_debouncer_if.sv
// ---------------------------------------------------------------------------
// switch_debouncer_if
// Bundles the switch input and the conditioned outputs of switch_debouncer.
//   sw_raw  - asynchronous switch pins (driven by the board / bench)
//   s_out   - debounced switch vector
//   changed - one-cycle strobe when s_out updates
//   rise    - per-bit 0->1 pulse on s_out
//   fall    - per-bit 1->0 pulse on s_out
//   stable  - candidate matches s_out and the stability count is saturated
// Modports:
//   master - the debouncer (consumes sw_raw, produces the rest)
//   slave  - the consumer / pin driver side
// ---------------------------------------------------------------------------
interface switch_debouncer_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] s_out;
    logic             changed;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             stable;

    modport master (
        input  sw_raw,
        output s_out,
        output changed,
        output rise,
        output fall,
        output stable
    );

    modport slave (
        output sw_raw,
        input  s_out,
        input  changed,
        input  rise,
        input  fall,
        input  stable
    );

endinterface

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer, one independent chain per bit.
//   clk   - destination clock
//   reset - synchronous, active-low reset (clears both stages)
//   d     - asynchronous input vector
//   q     - synchronized output (second stage), no combinational path from d
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic sync1_reg;
            logic sync2_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= d[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            assign q[gi] = sync2_reg;
        end
    endgenerate

endmodule

// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
// Synchronizes the raw DIP-switch vector and debounces it as one vector:
// the synchronized value must stay unchanged for DEBOUNCE_CYCLES
// consecutive edges before it is committed to s_out. Any bit change
// restarts the count for the whole vector.
//   clk   - system clock (48 MHz)
//   reset - synchronous, active-low reset
//   bus   - switch_debouncer_if master: sw_raw in; s_out, changed,
//           rise, fall, stable out (all registered)
// ---------------------------------------------------------------------------
module switch_debouncer
    import lab1_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    switch_debouncer_if.master  bus
);

    // Count value at which the candidate has been stable long enough.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync2;

    logic [WIDTH-1:0] cand_reg,    cand_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [WIDTH-1:0] s_out_reg,   s_out_next;
    logic             changed_reg, changed_next;
    logic [WIDTH-1:0] rise_reg,    rise_next;
    logic [WIDTH-1:0] fall_reg,    fall_next;
    logic             stable_reg,  stable_next;

    logic             cnt_full;
    logic             cand_held;
    logic             commit;
    logic [WIDTH-1:0] edge_rise;
    logic [WIDTH-1:0] edge_fall;

    sync_2ff #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.sw_raw),
        .q     (sync2)
    );

    assign cnt_full  = (cnt_reg == CNT_MAX);
    assign cand_held = (sync2 == cand_reg);
    // Commit only when the settled candidate actually differs from s_out;
    // a bounce that returns to the current value produces no pulses.
    assign commit    = cnt_full && cand_held && (cand_reg != s_out_reg);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_edge
            assign edge_rise[gi] =  cand_reg[gi] & ~s_out_reg[gi];
            assign edge_fall[gi] = ~cand_reg[gi] &  s_out_reg[gi];
        end
    endgenerate

    always_comb begin
        cand_next    = cand_reg;
        cnt_next     = cnt_reg;
        s_out_next   = s_out_reg;
        changed_next = 1'b0;
        rise_next    = '0;
        fall_next    = '0;

        if (!cand_held) begin
            cand_next = sync2;
            cnt_next  = '0;
        end else if (!cnt_full) begin
            cnt_next = cnt_reg + 1'b1;
        end

        if (commit) begin
            s_out_next   = cand_reg;
            changed_next = 1'b1;
            rise_next    = edge_rise;
            fall_next    = edge_fall;
        end

        // Compared against the post-edge s_out so stable rises together
        // with a commit rather than one cycle later.
        stable_next = cnt_full && cand_held && (cand_reg == s_out_next);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cand_reg    <= '0;
            cnt_reg     <= '0;
            s_out_reg   <= '0;
            changed_reg <= 1'b0;
            rise_reg    <= '0;
            fall_reg    <= '0;
            stable_reg  <= 1'b0;
        end else begin
            cand_reg    <= cand_next;
            cnt_reg     <= cnt_next;
            s_out_reg   <= s_out_next;
            changed_reg <= changed_next;
            rise_reg    <= rise_next;
            fall_reg    <= fall_next;
            stable_reg  <= stable_next;
        end
    end

    assign bus.s_out   = s_out_reg;
    assign bus.changed = changed_reg;
    assign bus.rise    = rise_reg;
    assign bus.fall    = fall_reg;
    assign bus.stable  = stable_reg;

endmodule

// File: tb/tb_switch_debouncer.sv
// ---------------------------------------------------------------------------
// tb_switch_debouncer
// Two instances share sw_raw and reset: u_dut_a (DEBOUNCE_CYCLES=4) and
// u_dut_b (DEBOUNCE_CYCLES=1). Every posedge a reference model computes the
// expected outputs and pushes them on a queue per instance; every negedge
// the entry is popped and compared. Directed checks add latency and
// pulse-count expectations from the test plan.
// ---------------------------------------------------------------------------
module tb_switch_debouncer;

    typedef struct packed {
        logic [3:0]  sync1;
        logic [3:0]  sync2;
        logic [3:0]  cand;
        logic [31:0] cnt;
        logic [3:0]  s_out;
        logic        changed;
        logic [3:0]  rise;
        logic [3:0]  fall;
        logic        stable;
    } model_t;

    logic       clk;
    logic       reset;
    logic [3:0] sw_raw;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_total = 0;
    int p0;

    model_t m_a = '0;
    model_t m_b = '0;
    model_t e_a;
    model_t e_b;
    model_t exp_a[$];
    model_t exp_b[$];

    switch_debouncer_if #(.WIDTH(4)) if_a ();
    switch_debouncer_if #(.WIDTH(4)) if_b ();

    assign if_a.sw_raw = sw_raw;
    assign if_b.sw_raw = sw_raw;

    switch_debouncer #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    switch_debouncer #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (1)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural reference: one clock edge of the debouncer.
    function automatic model_t model_step(input model_t m, input logic rst_n,
                                          input logic [3:0] raw, input int d);
        model_t n;
        logic   go;
        n = m;
        n.changed = 1'b0;
        n.rise    = 4'b0;
        n.fall    = 4'b0;
        if (!rst_n) begin
            n = '0;
        end else begin
            n.sync1 = raw;
            n.sync2 = m.sync1;
            if (m.sync2 != m.cand) begin
                n.cand = m.sync2;
                n.cnt  = 0;
            end else if (int'(m.cnt) < d - 1) begin
                n.cnt = m.cnt + 1;
            end
            go = (int'(m.cnt) == d - 1) && (m.sync2 == m.cand) && (m.cand != m.s_out);
            if (go) begin
                n.s_out   = m.cand;
                n.changed = 1'b1;
                n.rise    = m.cand & ~m.s_out;
                n.fall    = ~m.cand & m.s_out;
            end
            n.stable = (int'(m.cnt) == d - 1) && (m.sync2 == m.cand) && (m.cand == n.s_out);
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m_a = model_step(m_a, reset, sw_raw, 4);
        m_b = model_step(m_b, reset, sw_raw, 1);
        exp_a.push_back(m_a);
        exp_b.push_back(m_b);
    end

    always @(negedge clk) begin
        if (exp_a.size() > 0) begin
            e_a = exp_a.pop_front();
            check("a_s_out",   32'(if_a.s_out),   32'(e_a.s_out));
            check("a_changed", 32'(if_a.changed), 32'(e_a.changed));
            check("a_rise",    32'(if_a.rise),    32'(e_a.rise));
            check("a_fall",    32'(if_a.fall),    32'(e_a.fall));
            check("a_stable",  32'(if_a.stable),  32'(e_a.stable));
        end
        if (exp_b.size() > 0) begin
            e_b = exp_b.pop_front();
            check("b_s_out",   32'(if_b.s_out),   32'(e_b.s_out));
            check("b_changed", 32'(if_b.changed), 32'(e_b.changed));
            check("b_rise",    32'(if_b.rise),    32'(e_b.rise));
            check("b_fall",    32'(if_b.fall),    32'(e_b.fall));
            check("b_stable",  32'(if_b.stable),  32'(e_b.stable));
        end
        if (if_a.changed === 1'b1) pulse_total++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset  = 1'b0;
        sw_raw = 4'b0000;
        tick(3);
        reset = 1'b1;

        // Idle: zero input, no pulses, stable once the count saturates.
        tick(20);
        check("idle_s_out",  32'(if_a.s_out),  32'h0);
        check("idle_stable", 32'(if_a.stable), 32'h1);
        check("idle_pulses", 32'(pulse_total), 32'h0);
        $display("txn idle: s_out=%b stable=%b", if_a.s_out, if_a.stable);

        // 0000 -> 1010 held: commit at edge 6.
        sw_raw = 4'b1010;
        tick(6);
        check("t2_early_s_out", 32'(if_a.s_out), 32'h0);
        tick(1);
        check("t2_s_out",   32'(if_a.s_out),   32'hA);
        check("t2_changed", 32'(if_a.changed), 32'h1);
        check("t2_rise",    32'(if_a.rise),    32'hA);
        check("t2_fall",    32'(if_a.fall),    32'h0);
        tick(1);
        check("t2_changed_drop", 32'(if_a.changed), 32'h0);
        check("t2_rise_drop",    32'(if_a.rise),    32'h0);
        $display("txn step 1010: s_out=%b", if_a.s_out);
        tick(10);

        // Glitch sampled for 4 edges: rejected.
        p0 = pulse_total;
        sw_raw = 4'b1011;
        tick(4);
        sw_raw = 4'b1010;
        tick(12);
        check("g4_s_out",  32'(if_a.s_out),          32'hA);
        check("g4_pulses", 32'(pulse_total - p0),    32'h0);
        $display("txn glitch4: s_out=%b", if_a.s_out);

        // Excursion sampled for 5 edges: commits at edge 6.
        sw_raw = 4'b1011;
        tick(5);
        sw_raw = 4'b1010;
        tick(1);
        check("g5_early_s_out", 32'(if_a.s_out), 32'hA);
        tick(1);
        check("g5_s_out",   32'(if_a.s_out),   32'hB);
        check("g5_changed", 32'(if_a.changed), 32'h1);
        check("g5_rise",    32'(if_a.rise),    32'h1);
        $display("txn glitch5: s_out=%b rise=%b", if_a.s_out, if_a.rise);
        tick(14);
        check("g5_return_s_out", 32'(if_a.s_out), 32'hA);

        // Bounce on bit 0, then hold 1: exactly one commit.
        p0 = pulse_total;
        for (int i = 0; i < 6; i++) begin
            sw_raw[0] = ~sw_raw[0];
            tick(2);
        end
        sw_raw[0] = 1'b1;
        tick(6);
        check("bounce_early_s_out", 32'(if_a.s_out), 32'hA);
        tick(1);
        check("bounce_s_out",   32'(if_a.s_out),   32'hB);
        check("bounce_changed", 32'(if_a.changed), 32'h1);
        tick(5);
        check("bounce_pulses", 32'(pulse_total - p0), 32'h1);
        $display("txn bounce: s_out=%b pulses=%0d", if_a.s_out, pulse_total - p0);

        // Reset mid-count from 1111 while 0110 is held.
        sw_raw = 4'b1111;
        tick(12);
        check("rst_pre_s_out", 32'(if_a.s_out), 32'hF);
        sw_raw = 4'b0110;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_s_out_0", 32'(if_a.s_out), 32'h0);
        tick(1);
        check("rst_s_out_1", 32'(if_a.s_out), 32'h0);
        reset = 1'b1;
        tick(6);
        check("rst_early_s_out", 32'(if_a.s_out), 32'h0);
        tick(1);
        check("rst_s_out",   32'(if_a.s_out),   32'h6);
        check("rst_rise",    32'(if_a.rise),    32'h6);
        check("rst_changed", 32'(if_a.changed), 32'h1);
        $display("txn reset-mid: s_out=%b rise=%b", if_a.s_out, if_a.rise);

        // DEBOUNCE_CYCLES=1 instance: latency 3.
        sw_raw = 4'b0000;
        tick(12);
        check("d1_pre_s_out", 32'(if_b.s_out), 32'h0);
        sw_raw = 4'b0001;
        tick(3);
        check("d1_early_s_out", 32'(if_b.s_out), 32'h0);
        tick(1);
        check("d1_s_out",   32'(if_b.s_out),   32'h1);
        check("d1_changed", 32'(if_b.changed), 32'h1);
        tick(1);
        check("d1_changed_drop", 32'(if_b.changed), 32'h0);
        $display("txn d1: s_out=%b", if_b.s_out);

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input conditioner between the raw 4-bit DIP-switch pins and the LED controller's `s` input.
- Synchronizes the asynchronous switch vector into `clk`, then debounces it as a whole vector.
- Presents a clean, registered `s_out` plus per-bit rise/fall event pulses and a vector-changed strobe.
- Replaces the direct pin-to-`s` wiring so downstream logic only ever sees stable, glitch-free switch states.

Parameters:
- WIDTH, 4: number of switch bits.
- DEBOUNCE_CYCLES, 480000: consecutive stable cycles required (10 ms at 48 MHz HSOSC). Legal range ≥1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): stability counter width. Derived; do not override.

Ports:
- clk  in  1  system clock, 48 MHz
- reset  in  1  synchronous, active-low reset
- sw_raw  in  WIDTH  asynchronous switch pins
- s_out  out  WIDTH  debounced switch vector, registered
- changed  out  1  one-cycle pulse when s_out updates
- rise  out  WIDTH  one-cycle per-bit pulse, bit went 0->1 in s_out
- fall  out  WIDTH  one-cycle per-bit pulse, bit went 1->0 in s_out
- stable  out  1  high while candidate == s_out and counter saturated

Behaviour:
- Reset (reset==0 at posedge clk): sync regs, candidate, counter, s_out, changed, rise, fall and stable all go to 0. Reset takes priority over every other event.
- Synchronizer: 2 flops per bit, `sync1 <= sw_raw`, `sync2 <= sync1`. No combinational path from sw_raw.
- Candidate/counter, evaluated at each edge using the registered `sync2`:
  - sync2 != candidate: candidate <= sync2; counter <= 0.
  - sync2 == candidate and counter < DEBOUNCE_CYCLES-1: counter++.
  - sync2 == candidate and counter == DEBOUNCE_CYCLES-1: counter holds (saturates, no wrap).
- Any bit change restarts the whole vector's count. Bits are not debounced independently.
- Commit: at an edge where counter == DEBOUNCE_CYCLES-1, sync2 == candidate and candidate != s_out:
  - s_out <= candidate; changed <= 1.
  - rise <= candidate & ~s_out; fall <= ~candidate & s_out.
  - On all other edges, changed, rise and fall are 0.
- stable <= (counter == DEBOUNCE_CYCLES-1) && (sync2 == candidate) && (candidate == s_out after this edge).
- Latency: raw change first sampled at edge 0 and held -> s_out updates at edge DEBOUNCE_CYCLES+2. Pulses are high for the following cycle only.
- Glitch rejection:
  - A raw excursion sampled for ≤ DEBOUNCE_CYCLES edges never reaches s_out.
  - One sampled for DEBOUNCE_CYCLES+1 edges commits.
- Return to old value: if raw returns to the current s_out before commit, candidate == s_out, so no pulse fires. stable reasserts after the count saturates.
- Reset mid-count: the count is discarded and s_out is forced to 0. After release, a non-zero held switch value commits at DEBOUNCE_CYCLES+2 edges, with changed and rise pulses.
- DEBOUNCE_CYCLES==1: counter is always 0 and the commit occurs the edge after the candidate load (latency 3).

Decomposition:
- Package `lab1_pkg`:
  - constant CLK_HZ = 48_000_000
  - constant DEBOUNCE_MS = 10
  - derived DEBOUNCE_CYCLES_DEFAULT
  - typedef logic [3:0] sw_t
- Sub-module `sync_2ff`, parameterized WIDTH: the two-flop synchronizer with synchronous active-low reset. Instantiated once.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Reset then hold sw_raw=4'b0000 for 20 cycles -> s_out=0; changed, rise and fall never assert; stable=1 from edge 6 onward.
- sw_raw 0000->1010 at edge 0, held -> s_out=1010 at edge 6; changed=1, rise=1010, fall=0000 for exactly one cycle.
- From s_out=1010, pulse sw_raw to 1011 for 4 sampled edges, then back -> s_out stays 1010; no pulses. Repeat with 5 edges -> s_out=1011 at edge 6, rise=0001.
- Bounce: toggle sw_raw[0] every 2 cycles for 12 cycles, then hold 1 -> a single commit 6 edges after the last toggle; exactly one changed pulse.
- From s_out=1111, hold sw_raw=0110 and assert reset at edge 3 for 2 cycles -> s_out=0 during reset. After release, s_out=0110 at release+6 with rise=0110.
- DEBOUNCE_CYCLES=1: sw_raw 0000->0001 -> s_out=0001 at edge 3; changed pulse at edge 3 only.
